ascon_ctrl_fsm: RTL and testbench

//  Sequencer for the ASCON-128 encryption datapath. It drives the round counter, the register enables and the XOR/mux selects.
//  It covers the whole flow: initialisation, associated-data (AD) absorption, plaintext (PT) encryption, finalisation and tag output.
//  It sits between the host block interface (start / valid / ready / last) and the permutation datapath.

---
 rtl/ascon_ctrl_fsm.sv | 182 ++++++++++++++++++
 tb/tb_ascon_ctrl_fsm.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_ctrl_fsm.sv
// Sequencer for the ASCON-128 encryption datapath: init, AD absorption, PT encryption, finalisation, tag.
// Moore decode of state+counter; only en_data_o passes data_valid_i through combinationally.
module ascon_ctrl_fsm #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic       data_last_i,
  output logic       data_ready_o,
  output logic       en_data_o,
  output logic [3:0] round_o,
  output logic       en_state_o,
  output logic       init_o,
  output logic       xor_data_o,
  output logic       xor_key_begin_o,
  output logic       xor_key_end_o,
  output logic       xor_lsb_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT_AD,
    S_AD,
    S_WAIT_PT,
    S_PT,
    S_FINAL,
    S_DONE
  } state_t;

  // p^a in INIT counts 0..ROUNDS_A-1; every other permutation ends on round 11.
  localparam logic [3:0] C_INIT_END = 4'(ROUNDS_A - 1);
  localparam logic [3:0] C_A_START  = 4'(12 - ROUNDS_A);
  localparam logic [3:0] C_B_START  = 4'(12 - ROUNDS_B);
  localparam logic [3:0] C_LAST     = 4'd11;

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_cnt;
  logic [3:0] w_next_cnt;
  logic       r_last;
  logic       w_next_last;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_last  <= w_next_last;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_next_cnt      = r_cnt;
    w_next_last     = r_last;
    data_ready_o    = 1'b0;
    round_o         = 4'd0;
    en_state_o      = 1'b0;
    init_o          = 1'b0;
    xor_data_o      = 1'b0;
    xor_key_begin_o = 1'b0;
    xor_key_end_o   = 1'b0;
    xor_lsb_o       = 1'b0;
    en_cipher_o     = 1'b0;
    en_tag_o        = 1'b0;
    busy_o          = (r_state != S_IDLE);
    done_o          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next_state = S_INIT;
          w_next_cnt   = 4'd0;
        end
      end

      S_INIT: begin
        en_state_o = 1'b1;
        round_o    = r_cnt;
        init_o     = (r_cnt == 4'd0);
        if (r_cnt == C_INIT_END) begin
          xor_key_end_o = 1'b1;
          w_next_state  = S_WAIT_AD;
        end else begin
          w_next_cnt = r_cnt + 4'd1;
        end
      end

      S_WAIT_AD: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          w_next_last  = data_last_i;
          w_next_cnt   = C_B_START;
          w_next_state = S_AD;
        end
      end

      S_AD: begin
        en_state_o = 1'b1;
        round_o    = r_cnt;
        xor_data_o = (r_cnt == C_B_START);
        if (r_cnt == C_LAST) begin
          if (r_last) begin
            xor_lsb_o    = 1'b1;
            w_next_state = S_WAIT_PT;
          end else begin
            w_next_state = S_WAIT_AD;
          end
        end else begin
          w_next_cnt = r_cnt + 4'd1;
        end
      end

      S_WAIT_PT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          w_next_last = data_last_i;
          // The last PT block is absorbed by the first round of finalisation.
          if (data_last_i) begin
            w_next_cnt   = C_A_START;
            w_next_state = S_FINAL;
          end else begin
            w_next_cnt   = C_B_START;
            w_next_state = S_PT;
          end
        end
      end

      S_PT: begin
        en_state_o  = 1'b1;
        round_o     = r_cnt;
        xor_data_o  = (r_cnt == C_B_START);
        en_cipher_o = (r_cnt == C_B_START);
        if (r_cnt == C_LAST) begin
          w_next_state = S_WAIT_PT;
        end else begin
          w_next_cnt = r_cnt + 4'd1;
        end
      end

      S_FINAL: begin
        en_state_o = 1'b1;
        round_o    = r_cnt;
        if (r_cnt == C_A_START) begin
          xor_data_o      = 1'b1;
          en_cipher_o     = 1'b1;
          xor_key_begin_o = 1'b1;
        end
        if (r_cnt == C_LAST) begin
          xor_key_end_o = 1'b1;
          en_tag_o      = 1'b1;
          w_next_state  = S_DONE;
        end else begin
          w_next_cnt = r_cnt + 4'd1;
        end
      end

      S_DONE: begin
        done_o       = 1'b1;
        w_next_state = S_IDLE;
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign en_data_o = data_ready_o & data_valid_i;

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Randomized bench for ascon_ctrl_fsm: expected traces are built phase by phase from the message shape.
module tb_ascon_ctrl_fsm;
  localparam int RA = 12;
  localparam int RB = 6;

  // Output vector bit positions
  localparam int B_RDY  = 15;
  localparam int B_ED   = 14;
  localparam int B_ES   = 9;
  localparam int B_INIT = 8;
  localparam int B_KB   = 6;
  localparam int B_KE   = 5;
  localparam int B_LSB  = 4;
  localparam int B_CI   = 3;
  localparam int B_TAG  = 2;
  localparam int B_DONE = 0;

  logic       clock_i = 1'b0;
  logic       resetb_i = 1'b0;
  logic       start_i = 1'b0;
  logic       data_valid_i = 1'b0;
  logic       data_last_i = 1'b0;
  logic       data_ready_o, en_data_o, en_state_o, init_o, xor_data_o;
  logic       xor_key_begin_o, xor_key_end_o, xor_lsb_o, en_cipher_o, en_tag_o;
  logic       busy_o, done_o;
  logic [3:0] round_o;

  always #5 clock_i = ~clock_i;

  ascon_ctrl_fsm #(.ROUNDS_A(RA), .ROUNDS_B(RB)) dut (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i),
    .data_valid_i(data_valid_i), .data_last_i(data_last_i),
    .data_ready_o(data_ready_o), .en_data_o(en_data_o), .round_o(round_o),
    .en_state_o(en_state_o), .init_o(init_o), .xor_data_o(xor_data_o),
    .xor_key_begin_o(xor_key_begin_o), .xor_key_end_o(xor_key_end_o),
    .xor_lsb_o(xor_lsb_o), .en_cipher_o(en_cipher_o), .en_tag_o(en_tag_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  typedef struct packed {
    logic        start;
    logic        valid;
    logic        last;
    logic [15:0] out;
  } step_t;

  step_t       plan_q[$];
  logic [15:0] obs_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          noise = 0;

  function automatic logic [15:0] vec(int rdy, int ed, int rnd, int es, int ini, int xd, int kb,
                                      int ke, int lsb, int ci, int tag, int busy, int done);
    logic [3:0] r;
    r = 4'(rnd);
    return {rdy[0], ed[0], r, es[0], ini[0], xd[0], kb[0], ke[0], lsb[0], ci[0], tag[0],
            busy[0], done[0]};
  endfunction

  function automatic logic [15:0] observe();
    return {data_ready_o, en_data_o, round_o, en_state_o, init_o, xor_data_o, xor_key_begin_o,
            xor_key_end_o, xor_lsb_o, en_cipher_o, en_tag_o, busy_o, done_o};
  endfunction

  function automatic logic nz();
    return noise ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  function automatic int count_bit(int b);
    int c = 0;
    foreach (obs_q[i]) if (obs_q[i][b]) c++;
    return c;
  endfunction

  function automatic int first_idx(int b);
    foreach (obs_q[i]) if (obs_q[i][b]) return i;
    return -1;
  endfunction

  task automatic push(input logic s, input logic v, input logic l, input logic [15:0] o);
    step_t st;
    st.start = s; st.valid = v; st.last = l; st.out = o;
    plan_q.push_back(st);
  endtask

  // One message: idle, start, p^a init, AD blocks, PT blocks (last one folded into finalisation), done.
  task automatic gen_message(input int n_ad, input int n_pt, input int ad_stall, input int pt_stall);
    int s;
    int lst;
    push(1'b0, nz(), nz(), '0);
    push(1'b1, nz(), nz(), '0);
    for (int i = 0; i < RA; i++)
      push(nz(), nz(), nz(), vec(0, 0, i, 1, i == 0, 0, 0, i == RA - 1, 0, 0, 0, 1, 0));
    for (int k = 0; k < n_ad; k++) begin
      s = (ad_stall < 0) ? int'($urandom_range(0, 3)) : ad_stall;
      repeat (s) push(nz(), 1'b0, nz(), vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      lst = (k == n_ad - 1);
      push(nz(), 1'b1, lst[0], vec(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      for (int j = 0; j < RB; j++)
        push(nz(), nz(), nz(),
             vec(0, 0, 12 - RB + j, 1, 0, j == 0, 0, 0, lst != 0 && j == RB - 1, 0, 0, 1, 0));
    end
    for (int k = 0; k < n_pt; k++) begin
      s = (pt_stall < 0) ? int'($urandom_range(0, 3)) : pt_stall;
      repeat (s) push(nz(), 1'b0, nz(), vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      lst = (k == n_pt - 1);
      push(nz(), 1'b1, lst[0], vec(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      if (lst == 0) begin
        for (int j = 0; j < RB; j++)
          push(nz(), nz(), nz(), vec(0, 0, 12 - RB + j, 1, 0, j == 0, 0, 0, 0, j == 0, 0, 1, 0));
      end else begin
        for (int j = 0; j < RA; j++)
          push(nz(), nz(), nz(), vec(0, 0, 12 - RA + j, 1, 0, j == 0, j == 0, j == RA - 1, 0,
                                     j == 0, j == RA - 1, 1, 0));
      end
    end
    push(nz(), nz(), nz(), vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
  endtask

  // Drives the first n planned steps and records outputs at the falling edge.
  task automatic play_n(input int n);
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      start_i      = plan_q[i].start;
      data_valid_i = plan_q[i].valid;
      data_last_i  = plan_q[i].last;
      @(negedge clock_i);
      obs_q.push_back(observe());
      @(posedge clock_i);
      #1;
    end
    start_i = 1'b0; data_valid_i = 1'b0; data_last_i = 1'b0;
  endtask

  task automatic test_reset();
    resetb_i = 1'b0; start_i = 1'b1; data_valid_i = 1'b1; data_last_i = 1'b1;
    repeat (2) @(posedge clock_i);
    #1;
    checks++;
    if (observe() !== 16'h0) begin
      errors++; $display("FAIL reset_outputs: got %b want 0", observe());
    end
    @(negedge clock_i);
    start_i = 1'b0; data_valid_i = 1'b0; data_last_i = 1'b0;
    resetb_i = 1'b1;
    @(posedge clock_i);
    #1;
    checks++;
    if (observe() !== 16'h0) begin
      errors++; $display("FAIL reset_idle: got %b want 0", observe());
    end
  endtask

  task automatic test_init();
    int rdy_at;
    noise = 0; plan_q.delete();
    gen_message(1, 1, 0, 0);
    play_n(plan_q.size());
    for (int i = 0; i < plan_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== plan_q[i].out) begin
        errors++; $display("FAIL init step %0d: got %b want %b", i, obs_q[i], plan_q[i].out);
      end
    end
    // start sampled at step 1 -> first ready 13 cycles later
    rdy_at = first_idx(B_RDY);
    checks++;
    if (rdy_at !== 14) begin errors++; $display("FAIL init_ready_cycle: got %0d want 14", rdy_at); end
    checks++;
    if (count_bit(B_INIT) !== 1) begin
      errors++; $display("FAIL init_pulses: got %0d want 1", count_bit(B_INIT));
    end
  endtask

  task automatic test_full_message();
    int d;
    noise = 0; plan_q.delete();
    gen_message(1, 2, 0, 0);
    play_n(plan_q.size());
    for (int i = 0; i < plan_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== plan_q[i].out) begin
        errors++; $display("FAIL full step %0d: got %b want %b", i, obs_q[i], plan_q[i].out);
      end
    end
    d = first_idx(B_DONE) - 1;
    checks++;
    if (d !== 40) begin errors++; $display("FAIL full_start_to_done: got %0d want 40", d); end
    checks++;
    if (count_bit(B_CI) !== 2) begin
      errors++; $display("FAIL full_cipher_count: got %0d want 2", count_bit(B_CI));
    end
    checks++;
    if (count_bit(B_TAG) !== 1 || count_bit(B_DONE) !== 1) begin
      errors++; $display("FAIL full_tag_done: got %0d/%0d want 1/1", count_bit(B_TAG), count_bit(B_DONE));
    end
  endtask

  task automatic test_stall();
    noise = 0; plan_q.delete();
    gen_message(1, 1, 5, 0);
    play_n(plan_q.size());
    for (int i = 0; i < plan_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== plan_q[i].out) begin
        errors++; $display("FAIL stall step %0d: got %b want %b", i, obs_q[i], plan_q[i].out);
      end
    end
    checks++;
    if (count_bit(B_RDY) !== 7) begin
      errors++; $display("FAIL stall_ready_cycles: got %0d want 7", count_bit(B_RDY));
    end
  endtask

  task automatic test_ignored_inputs();
    noise = 1; plan_q.delete();
    gen_message(2, 2, 0, 0);
    play_n(plan_q.size());
    for (int i = 0; i < plan_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== plan_q[i].out) begin
        errors++; $display("FAIL ignored step %0d: got %b want %b", i, obs_q[i], plan_q[i].out);
      end
    end
    checks++;
    if (count_bit(B_ED) !== 4) begin
      errors++; $display("FAIL ignored_accepts: got %0d want 4", count_bit(B_ED));
    end
    noise = 0;
  endtask

  task automatic test_multi_ad();
    int third_acc;
    int n_acc;
    noise = 0; plan_q.delete();
    gen_message(3, 1, -1, 0);
    play_n(plan_q.size());
    for (int i = 0; i < plan_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== plan_q[i].out) begin
        errors++; $display("FAIL multi_ad step %0d: got %b want %b", i, obs_q[i], plan_q[i].out);
      end
    end
    third_acc = -1; n_acc = 0;
    foreach (obs_q[i]) if (obs_q[i][B_ED]) begin
      n_acc++;
      if (n_acc == 3) third_acc = i;
    end
    checks++;
    if (count_bit(B_LSB) !== 1) begin
      errors++; $display("FAIL multi_ad_lsb_count: got %0d want 1", count_bit(B_LSB));
    end
    checks++;
    if (first_idx(B_LSB) !== third_acc + RB) begin
      errors++; $display("FAIL multi_ad_lsb_cycle: got %0d want %0d", first_idx(B_LSB), third_acc + RB);
    end
  endtask

  task automatic test_back_to_back_random();
    noise = 1; plan_q.delete();
    for (int m = 0; m < 6; m++)
      gen_message(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), -1, -1);
    play_n(plan_q.size());
    for (int i = 0; i < plan_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== plan_q[i].out) begin
        errors++; $display("FAIL random step %0d: got %b want %b", i, obs_q[i], plan_q[i].out);
      end
    end
    checks++;
    if (count_bit(B_DONE) !== 6) begin
      errors++; $display("FAIL random_done_count: got %0d want 6", count_bit(B_DONE));
    end
    noise = 0;
  endtask

  task automatic test_reset_mid_final();
    int f;
    int idx;
    noise = 0; plan_q.delete();
    gen_message(1, 1, 0, 0);
    f = -1;
    foreach (plan_q[i]) if (f < 0 && plan_q[i].out[B_KB]) f = i;
    play_n(f + 5);
    checks++;
    if (round_o !== 4'(12 - RA + 5) || en_state_o !== 1'b1) begin
      errors++; $display("FAIL midfinal_position: got round %0d en %b want %0d 1", round_o, en_state_o, 12 - RA + 5);
    end
    resetb_i = 1'b0;
    #1;
    checks++;
    if (observe() !== 16'h0) begin errors++; $display("FAIL midfinal_async: got %b want 0", observe()); end
    @(posedge clock_i);
    #1;
    checks++;
    if (observe() !== 16'h0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL midfinal_edge: got %b want 0", observe());
    end
    @(negedge clock_i);
    resetb_i = 1'b1;
    @(posedge clock_i);
    #1;
    plan_q.delete();
    gen_message(1, 1, 0, 0);
    play_n(plan_q.size());
    for (int i = 0; i < plan_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== plan_q[i].out) begin
        errors++; $display("FAIL post_reset step %0d: got %b want %b", i, obs_q[i], plan_q[i].out);
      end
    end
    idx = first_idx(B_DONE);
    checks++;
    if (idx < 0) begin errors++; $display("FAIL post_reset_done: got none want one pulse"); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_full_message();
    test_stall();
    test_ignored_inputs();
    test_multi_ad();
    test_back_to_back_random();
    test_reset_mid_final();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
